burst_ram_responder: RTL and testbench

Synthesizable stand-in for the external burst RAM controller, i.e. the responder side of the burst RAM command interface driven by the cache.
- Accepts read/write commands, each moving BURST_COUNT 64-bit words in consecutive cycles, against an on-chip memory array.
- Reproduces controller timing: calibration busy after reset, fixed read latency, per-beat data-ready strobe.
- Used in simulation and in builds without external memory, so cache burst logic can be exercised end to end.

---
 rtl/burst_ram_responder.sv | 168 ++++++++++++++++
 tb/tb_burst_ram_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_ram_responder.sv
// Responder side of the burst RAM command interface, backed by an on-chip array.
// Emulates controller calibration busy time, fixed read latency and per-beat
// read strobes so cache burst logic can run without external memory.
module burst_ram_responder #(
   parameter int DEPTH_BITWIDTH           = 4,
   parameter int BURST_COUNT              = 4,
   parameter int CYCLES_BEFORE_DATA_VALID = 6,
   parameter int CYCLES_BEFORE_INITIATED  = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd,
   input  logic                      cmd_en,
   input  logic [DEPTH_BITWIDTH-1:0] addr,
   input  logic [63:0]               wr_data,
   input  logic [7:0]                data_mask,
   output logic [63:0]               rd_data,
   output logic                      rd_data_ready,
   output logic                      busy
);

   localparam int DEPTH   = 2 ** DEPTH_BITWIDTH;
   localparam int CNT_MAX = (CYCLES_BEFORE_INITIATED > CYCLES_BEFORE_DATA_VALID) ?
                            CYCLES_BEFORE_INITIATED : CYCLES_BEFORE_DATA_VALID;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int BEAT_W  = $clog2(BURST_COUNT + 1);

   localparam logic [CNT_W-1:0]          INIT_LAST = CNT_W'(CYCLES_BEFORE_INITIATED - 1);
   // Accept edge already consumed one cycle of latency, the entry edge into READ_BURST another.
   localparam logic [CNT_W-1:0]          WAIT_LOAD = CNT_W'(CYCLES_BEFORE_DATA_VALID - 2);
   localparam logic [CNT_W-1:0]          CNT_ONE   = CNT_W'(1);
   localparam logic [BEAT_W-1:0]         BEAT_ONE  = BEAT_W'(1);
   localparam logic [BEAT_W-1:0]         BEAT_LAST = BEAT_W'(BURST_COUNT - 1);
   localparam logic [BEAT_W-1:0]         BEAT_END  = BEAT_W'(BURST_COUNT);
   localparam logic [DEPTH_BITWIDTH-1:0] ADDR_ONE  = DEPTH_BITWIDTH'(1);

   typedef enum logic [2:0] {INIT, IDLE, READ_WAIT, READ_BURST, WRITE_BURST} state_t;

   state_t                    state, state_n;
   logic [CNT_W-1:0]          cnt, cnt_n;
   logic [BEAT_W-1:0]         beat, beat_n;
   logic [DEPTH_BITWIDTH-1:0] burst_addr, burst_addr_n;
   logic                      busy_n;
   logic                      rd_data_ready_n;
   logic [63:0]               rd_data_n;

   logic                      mem_we;
   logic [DEPTH_BITWIDTH-1:0] mem_waddr;
   logic [63:0]               mem_wdata;
   logic [63:0]               mem [DEPTH];

   // Byte mask is part of the interface but every write stores the full word.
   logic unused_mask;
   assign unused_mask = ^data_mask;

   // State and output registers; async reset returns to calibration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= INIT;
         cnt           <= '0;
         beat          <= '0;
         burst_addr    <= '0;
         busy          <= 1'b1;
         rd_data_ready <= 1'b0;
         rd_data       <= '0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         beat          <= beat_n;
         burst_addr    <= burst_addr_n;
         busy          <= busy_n;
         rd_data_ready <= rd_data_ready_n;
         rd_data       <= rd_data_n;
      end
   end

   // Memory array write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // Next-state logic: command acceptance, latency countdown and beat sequencing.
   always_comb begin
      state_n         = state;
      cnt_n           = cnt;
      beat_n          = beat;
      burst_addr_n    = burst_addr;
      busy_n          = busy;
      rd_data_ready_n = 1'b0;
      rd_data_n       = rd_data;
      mem_we          = 1'b0;
      mem_waddr       = burst_addr;
      mem_wdata       = wr_data;

      case (state)
         INIT: begin
            if (cnt == INIT_LAST) begin
               state_n = IDLE;
               busy_n  = 1'b0;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end

         IDLE: begin
            if (cmd_en) begin
               if (cmd) begin
                  // Beat 0 of a write arrives together with the command.
                  mem_we       = 1'b1;
                  mem_waddr    = addr;
                  burst_addr_n = addr + ADDR_ONE;
                  beat_n       = BEAT_ONE;
                  if (BURST_COUNT > 1) begin
                     state_n = WRITE_BURST;
                     busy_n  = 1'b1;
                  end
               end else begin
                  burst_addr_n = addr;
                  beat_n       = '0;
                  cnt_n        = WAIT_LOAD;
                  state_n      = READ_WAIT;
                  busy_n       = 1'b1;
               end
            end
         end

         READ_WAIT: begin
            if (cnt == '0) begin
               state_n = READ_BURST;
            end else begin
               cnt_n = cnt - CNT_ONE;
            end
         end

         READ_BURST: begin
            if (beat == BEAT_END) begin
               state_n = IDLE;
               busy_n  = 1'b0;
            end else begin
               rd_data_n       = mem[burst_addr];
               rd_data_ready_n = 1'b1;
               burst_addr_n    = burst_addr + ADDR_ONE;
               beat_n          = beat + BEAT_ONE;
            end
         end

         WRITE_BURST: begin
            mem_we       = 1'b1;
            burst_addr_n = burst_addr + ADDR_ONE;
            beat_n       = beat + BEAT_ONE;
            if (beat == BEAT_LAST) begin
               state_n = IDLE;
               busy_n  = 1'b0;
            end
         end

         default: begin
            state_n = INIT;
            busy_n  = 1'b1;
            cnt_n   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_burst_ram_responder.sv
// Bench for burst_ram_responder: table of commands against a memory model,
// read beats checked by a scoreboard, plus hand sequences for reset and busy corners.
module tb_burst_ram_responder;

   logic        clk;
   logic        rst;
   logic        cmd;
   logic        cmd_en;
   logic [3:0]  addr;
   logic [63:0] wr_data;
   logic [7:0]  data_mask;
   logic [63:0] rd_data;
   logic        rd_data_ready;
   logic        busy;

   burst_ram_responder dut (
      .clk           (clk),
      .rst           (rst),
      .cmd           (cmd),
      .cmd_en        (cmd_en),
      .addr          (addr),
      .wr_data       (wr_data),
      .data_mask     (data_mask),
      .rd_data       (rd_data),
      .rd_data_ready (rd_data_ready),
      .busy          (busy)
   );

   typedef struct {
      bit              wr;
      logic [3:0]      a;
      logic [7:0]      mask;
      logic [3:0][63:0] d;
      int              exp_busy;
   } vec_t;

   typedef struct {
      logic [63:0] data;
      int          cyc;
   } exp_t;

   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   exp_t        sbq[$];
   logic [63:0] tb_mem [16];
   vec_t        vecs [8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic vec_t mk(bit wr, logic [3:0] a, logic [7:0] m, logic [63:0] d0,
                               logic [63:0] d1, logic [63:0] d2, logic [63:0] d3, int eb);
      vec_t v;
      v.wr       = wr;
      v.a        = a;
      v.mask     = m;
      v.d        = {d3, d2, d1, d0};
      v.exp_busy = eb;
      return v;
   endfunction

   // Scoreboard: every read beat must match the oldest expected beat, in value and cycle.
   always @(negedge clk) begin
      if (rd_data_ready !== 1'b0) begin
         if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got rd_data_ready=%b rd_data=0x%0h, required no beat (cycle %0d)",
                     rd_data_ready, rd_data, cyc);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check("beat_data", rd_data, e.data);
            check("beat_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n == 100) check("idle_timeout", 64'(busy), 64'(0));
   endtask

   task automatic push_read(input logic [3:0] a, input int acc);
      for (int i = 0; i < 4; i++) begin
         exp_t e;
         logic [3:0] wa;
         wa     = a + 4'(i);
         e.data = tb_mem[wa];
         e.cyc  = acc + 6 + i;
         sbq.push_back(e);
      end
   endtask

   task automatic run_cmd(input vec_t v, input string tag);
      int n;
      int i;
      wait_idle();
      cmd       = v.wr;
      addr      = v.a;
      data_mask = v.mask;
      wr_data   = v.d[0];
      cmd_en    = 1'b1;
      if (v.wr) begin
         for (int k = 0; k < 4; k++) begin
            logic [3:0] wa;
            wa         = v.a + 4'(k);
            tb_mem[wa] = v.d[k];
         end
      end else begin
         push_read(v.a, cyc + 1);
      end
      @(negedge clk);
      cmd_en = 1'b0;
      n = 0;
      i = 1;
      while (busy === 1'b1 && n < 50) begin
         if (v.wr && i < 4) begin
            wr_data = v.d[i];
            i++;
         end
         n++;
         @(negedge clk);
      end
      check(tag, 64'(n), 64'(v.exp_busy));
   endtask

   initial begin
      int n;
      int acc;

      rst       = 1'b1;
      cmd       = 1'b0;
      cmd_en    = 1'b0;
      addr      = '0;
      wr_data   = '0;
      data_mask = '0;

      vecs[0] = mk(1'b1, 4'd4,  8'hFF, 64'h1111111111111111, 64'h2222222222222222,
                   64'h3333333333333333, 64'h4444444444444444, 3);
      vecs[1] = mk(1'b0, 4'd4,  8'hFF, '0, '0, '0, '0, 10);
      vecs[2] = mk(1'b1, 4'd0,  8'hFF, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                   64'hDEADBEEF00000002, 64'hCAFEF00D00000003, 3);
      vecs[3] = mk(1'b1, 4'd14, 8'h00, 64'hAAAA00000000000A, 64'hBBBB00000000000B,
                   64'hCCCC00000000000C, 64'hDDDD00000000000D, 3);
      vecs[4] = mk(1'b0, 4'd0,  8'hFF, '0, '0, '0, '0, 10);
      vecs[5] = mk(1'b0, 4'd14, 8'hFF, '0, '0, '0, '0, 10);
      vecs[6] = mk(1'b1, 4'd9,  8'hFF, 64'h5A5A5A5A5A5A5A5A, 64'hA5A5A5A5A5A5A5A5,
                   64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0, 3);
      vecs[7] = mk(1'b0, 4'd9,  8'hFF, '0, '0, '0, '0, 10);

      repeat (3) @(negedge clk);
      check("reset_busy", 64'(busy), 64'(1));
      check("reset_rd_data_ready", 64'(rd_data_ready), 64'(0));
      check("reset_rd_data", rd_data, 64'h0);

      // Calibration: busy for 10 edges, a read offered at the third edge is ignored.
      rst = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 50) begin
         if (n == 2) begin
            cmd_en = 1'b1;
            cmd    = 1'b0;
            addr   = 4'd4;
         end else begin
            cmd_en = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      cmd_en = 1'b0;
      check("init_busy_cycles", 64'(n), 64'(10));
      @(negedge clk);
      check("init_cmd_ignored", 64'(busy), 64'(0));
      repeat (10) @(negedge clk);

      for (int k = 0; k < 8; k++) begin
         run_cmd(vecs[k], $sformatf("vec%0d_busy", k));
      end
      repeat (2) @(negedge clk);
      check("table_drain", 64'(sbq.size()), 64'(0));

      // cmd_en held through a read burst: one burst, then the next command after busy falls.
      wait_idle();
      cmd    = 1'b0;
      addr   = 4'd4;
      cmd_en = 1'b1;
      push_read(4'd4, cyc + 1);
      @(negedge clk);
      addr = 4'd9;
      n = 0;
      while (busy === 1'b1 && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("held_first_busy", 64'(n), 64'(10));
      push_read(4'd9, cyc + 1);
      @(negedge clk);
      cmd_en = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("held_second_busy", 64'(n), 64'(10));
      repeat (3) @(negedge clk);
      check("held_drain", 64'(sbq.size()), 64'(0));

      // Reset during beat 2 of a read aborts the burst at once.
      wait_idle();
      cmd    = 1'b0;
      addr   = 4'd4;
      cmd_en = 1'b1;
      acc    = cyc + 1;
      push_read(4'd4, acc);
      @(negedge clk);
      cmd_en = 1'b0;
      n = 0;
      while (cyc < acc + 8 && n < 50) begin
         n++;
         @(negedge clk);
      end
      #2;
      rst = 1'b1;
      #1;
      check("abort_rd_data_ready", 64'(rd_data_ready), 64'(0));
      check("abort_busy", 64'(busy), 64'(1));
      check("abort_pending_beats", 64'(sbq.size()), 64'(1));
      sbq.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("abort_recal_cycles", 64'(n), 64'(10));

      // Memory contents survive reset.
      run_cmd(vecs[1], "post_reset_read_busy");
      repeat (3) @(negedge clk);
      check("final_drain", 64'(sbq.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
